rf_access_ctrl: RTL and testbench
=================================

# rf_access_ctrl

Access controller that shares the single-port 8-bit register file (accumulator at entry 0) between the processor core and a debug/loader port, and sequences a bulk clear of all entries. It sits between the core decode/writeback signals and the register file's write-enable, address, immediate-select and data inputs. It stalls the core while it holds the port, and it prevents starvation of the debug requester.

## Interface
- PW, 4, register address width; register file has 2**PW entries, address bus is PW+1 bits
- STARVE_LIMIT, 8, maximum cycles a pending debug request waits on core writes before the core is forcibly stalled
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- core_acc_wr  in  1  core accumulator write request
- core_reg_wr  in  1  core register write request
- core_imm  in  1  core immediate-select
- core_addr  in  PW+1  core register address / immediate
- core_dat  in  8  core write data
- core_stall  out  1  core must hold its current instruction; core_* inputs are ignored while high
- clr_start  in  1  single-cycle pulse requesting a bulk clear
- clr_busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse after the last entry is cleared
- dbg_req_valid  in  1  debug request pending
- dbg_req_write  in  1  1 = write, 0 = read
- dbg_addr  in  PW  debug register index
- dbg_wdat  in  8  debug write data
- dbg_req_ready  out  1  request accepted this cycle
- dbg_rsp_valid  out  1  response available
- dbg_rsp_ready  in  1  requester consumes response
- dbg_rdat  out  8  read data (write responses return the written value)
- rf_dat_in, rf_acc_write, rf_reg_write, rf_imm_val  out  8/1/1/1  to register file
- rf_addr  out  PW+1  to register file
- rf_reg_out  in  8  register file combinational read data

## Operation
- States: IDLE, CLEAR, DBG, RSP.
- IDLE: rf_* driven directly from core_*. core_stall=0.
  - A clr_start pulse sets clr_pend. clr_pend can be set in any state and is cleared on entry to CLEAR.
  - Priority out of IDLE: clr_pend -> CLEAR; else dbg_req_valid and (core_acc_wr=0 and core_reg_wr=0, or starve_cnt==STARVE_LIMIT) -> DBG.
- starve_cnt:
  - Increments in IDLE while dbg_req_valid=1 and a core write blocks the request; saturates at STARVE_LIMIT.
  - Cleared on entering DBG or when dbg_req_valid=0.
- CLEAR:
  - Signals: core_stall=1, clr_busy=1, rf_reg_write=1, rf_acc_write=0, rf_imm_val=0, rf_dat_in=0, rf_addr={0,clr_idx}.
  - clr_idx counts 0..2**PW-1, then -> IDLE with clr_done=1 for the first IDLE cycle.
  - clr_start while in CLEAR sets clr_pend, which triggers one more full clear afterwards.
- DBG (exactly one cycle):
  - Signals: core_stall=1, dbg_req_ready=1, rf_addr={0,dbg_addr}, rf_imm_val=0, rf_acc_write=0, rf_reg_write=dbg_req_write, rf_dat_in=dbg_wdat.
  - Captures dbg_rdat <= dbg_req_write ? dbg_wdat : rf_reg_out.
  - Next state is RSP.
- RSP:
  - dbg_rsp_valid=1; dbg_rdat held stable.
  - The core runs (core_stall=0, core pass-through).
  - -> IDLE on dbg_rsp_ready=1.
  - Clear and new debug requests wait until IDLE.
- Debug writes to index 0 go through rf_reg_write, never rf_acc_write.
- A core request with both core_acc_wr and core_reg_wr high is passed through unchanged; the register file gives accumulator priority.

## Timing
- Reset values: state=IDLE, starve_cnt=0, clr_idx=0, clr_pend=0, dbg_rdat=0, and all flag outputs 0. rf_* follow core_* combinationally because the state is IDLE.
- Reset asserted mid-CLEAR or mid-DBG/RSP aborts the operation. No clr_done is issued and no response is returned.
- Debug latency: request seen in IDLE at cycle N (not blocked) -> DBG at N+1 (ready, write committed at end of N+1) -> rsp_valid from N+2.
- Worst-case debug wait under continuous core writes: STARVE_LIMIT+1 cycles in IDLE before DBG.
- Clear: 2**PW cycles with core_stall high. clr_done occurs 2**PW+1 cycles after the CLEAR entry edge.
- core_stall is a registered-state decode. It is high exactly during CLEAR and DBG.
- dbg_req_ready is high only in DBG. Requester must hold request fields stable from assertion of dbg_req_valid through the ready cycle.

## Structure
- Package rf_ctrl_pkg holds: the state enum (IDLE, CLEAR, DBG, RSP), DATA_W=8, and the default PW and STARVE_LIMIT constants.
- One natural sub-module, rf_starve_timer, holds the saturating starve counter. It takes inputs pending, blocked, and clear, and outputs expired.
- The clear index and the FSM stay in rf_access_ctrl.

## Test plan
- Reset, then core writes core_reg_wr with addr 5, dat 0x3C -> rf_reg_write=1, rf_addr=5, rf_dat_in=0x3C in the same cycle, and core_stall=0.
- Debug write to index 7 with 0xA5 while the core is idle -> ready one cycle later, rf_reg_write with addr 7, then rsp_valid with dbg_rdat=0xA5. A subsequent debug read of index 7 returns 0xA5.
- Core writes every cycle while a debug read is pending -> debug is granted exactly after starve_cnt reaches 8, with core_stall high for that one cycle.
- clr_start pulse -> clr_busy high and core_stall high for 16 cycles, with addresses 0..15 written with 0. clr_done is pulsed once, and debug reads of 0 and 15 return 0x00.
- clr_start and dbg_req_valid in the same IDLE cycle -> CLEAR runs first, and debug is accepted after clr_done. dbg_rsp_ready held low in RSP keeps dbg_rdat stable for 5 cycles.
- reset asserted at clear index 6 -> next cycle IDLE with clr_busy=0, and no clr_done pulse is issued.

Source files
------------

// File: rtl/rf_ctrl_pkg.sv
// rf_ctrl_pkg: shared types and constants for the register-file access controller.
//   - rf_state_e     : controller state encoding (idle / bulk clear / debug access / debug response)
//   - DATA_W         : register file data width
//   - PW_DEFAULT     : default register address width (2**PW entries)
//   - STARVE_LIMIT_DEFAULT : default cycles a debug request may be blocked by core writes
package rf_ctrl_pkg;

    localparam int unsigned DATA_W               = 8;
    localparam int unsigned PW_DEFAULT           = 4;
    localparam int unsigned STARVE_LIMIT_DEFAULT = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StClear = 2'd1,
        StDbg   = 2'd2,
        StRsp   = 2'd3
    } rf_state_e;

endpackage

// File: rtl/rf_starve_timer.sv
// rf_starve_timer: saturating counter of cycles a pending debug request has been blocked.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_pending      : a debug request is waiting in a state where it may be granted
//   i_blocked      : a core write is holding the port this cycle
//   i_clear        : restart the count (request withdrawn or granted)
//   o_expired      : count has reached STARVE_LIMIT; the core must yield
module rf_starve_timer
    import rf_ctrl_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_pending,
    input  logic i_blocked,
    input  logic i_clear,
    output logic o_expired
);

    localparam int unsigned CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    always_comb begin
        w_cnt_next = r_cnt;
        if (i_clear) begin
            w_cnt_next = '0;
        end else if (i_pending && i_blocked && (r_cnt != LIMIT)) begin
            w_cnt_next = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    assign o_expired = (r_cnt == LIMIT);

endmodule

// File: rtl/rf_access_ctrl.sv
// rf_access_ctrl: arbitrates the single write port of the register file between the core and a
// debug/loader port, and sequences a bulk clear of every entry.
// Ports:
//   i_clk, i_reset                        : clock, synchronous active-high reset
//   i_core_acc_wr/reg_wr/imm/addr/dat     : core writeback/decode signals
//   o_core_stall                          : core must hold its instruction (CLEAR and DBG)
//   i_clr_start, o_clr_busy, o_clr_done   : bulk clear request / in progress / completion pulse
//   i_dbg_req_*, o_dbg_req_ready          : debug request channel (accepted in DBG)
//   o_dbg_rsp_valid, i_dbg_rsp_ready      : debug response handshake
//   o_dbg_rdat                            : captured read data (or written value for writes)
//   o_rf_dat_in/acc_write/reg_write/imm_val/addr : register file controls
//   i_rf_reg_out                          : register file combinational read data
module rf_access_ctrl
    import rf_ctrl_pkg::*;
#(
    parameter int unsigned PW           = PW_DEFAULT,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_reset,

    input  logic              i_core_acc_wr,
    input  logic              i_core_reg_wr,
    input  logic              i_core_imm,
    input  logic [PW:0]       i_core_addr,
    input  logic [DATA_W-1:0] i_core_dat,
    output logic              o_core_stall,

    input  logic              i_clr_start,
    output logic              o_clr_busy,
    output logic              o_clr_done,

    input  logic              i_dbg_req_valid,
    input  logic              i_dbg_req_write,
    input  logic [PW-1:0]     i_dbg_addr,
    input  logic [DATA_W-1:0] i_dbg_wdat,
    output logic              o_dbg_req_ready,
    output logic              o_dbg_rsp_valid,
    input  logic              i_dbg_rsp_ready,
    output logic [DATA_W-1:0] o_dbg_rdat,

    output logic [DATA_W-1:0] o_rf_dat_in,
    output logic              o_rf_acc_write,
    output logic              o_rf_reg_write,
    output logic              o_rf_imm_val,
    output logic [PW:0]       o_rf_addr,
    input  logic [DATA_W-1:0] i_rf_reg_out
);

    rf_state_e         r_state;
    rf_state_e         w_state_next;
    logic [PW-1:0]     r_clr_idx;
    logic              r_clr_pend;
    logic              r_clr_done;
    logic [DATA_W-1:0] r_dbg_rdat;

    logic w_core_wr;
    logic w_clr_pend;
    logic w_clr_last;
    logic w_enter_clear;
    logic w_enter_dbg;
    logic w_starve_expired;

    assign w_core_wr  = i_core_acc_wr | i_core_reg_wr;
    // A pulse arriving in IDLE is acted on in the same cycle so it beats a coincident debug request.
    assign w_clr_pend = r_clr_pend | i_clr_start;
    assign w_clr_last = (r_clr_idx == {PW{1'b1}});

    assign w_enter_clear = (r_state != StClear) && (w_state_next == StClear);
    assign w_enter_dbg   = (r_state != StDbg) && (w_state_next == StDbg);

    rf_starve_timer #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_timer (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_pending (i_dbg_req_valid && (r_state == StIdle)),
        .i_blocked (w_core_wr),
        .i_clear   (!i_dbg_req_valid || w_enter_dbg),
        .o_expired (w_starve_expired)
    );

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_clr_pend) begin
                    w_state_next = StClear;
                end else if (i_dbg_req_valid && (!w_core_wr || w_starve_expired)) begin
                    w_state_next = StDbg;
                end
            end
            StClear: begin
                if (w_clr_last) begin
                    w_state_next = StIdle;
                end
            end
            StDbg: begin
                w_state_next = StRsp;
            end
            StRsp: begin
                if (i_dbg_rsp_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Output decode; IDLE and RSP pass the core straight through.
    always_comb begin
        o_core_stall    = 1'b0;
        o_clr_busy      = 1'b0;
        o_dbg_req_ready = 1'b0;
        o_dbg_rsp_valid = 1'b0;
        o_rf_acc_write  = i_core_acc_wr;
        o_rf_reg_write  = i_core_reg_wr;
        o_rf_imm_val    = i_core_imm;
        o_rf_addr       = i_core_addr;
        o_rf_dat_in     = i_core_dat;
        unique case (r_state)
            StIdle: begin
            end
            StClear: begin
                o_core_stall   = 1'b1;
                o_clr_busy     = 1'b1;
                o_rf_acc_write = 1'b0;
                o_rf_reg_write = 1'b1;
                o_rf_imm_val   = 1'b0;
                o_rf_addr      = {1'b0, r_clr_idx};
                o_rf_dat_in    = '0;
            end
            StDbg: begin
                o_core_stall    = 1'b1;
                o_dbg_req_ready = 1'b1;
                // Entry 0 is written as a plain register, never via the accumulator path.
                o_rf_acc_write  = 1'b0;
                o_rf_reg_write  = i_dbg_req_write;
                o_rf_imm_val    = 1'b0;
                o_rf_addr       = {1'b0, i_dbg_addr};
                o_rf_dat_in     = i_dbg_wdat;
            end
            StRsp: begin
                o_dbg_rsp_valid = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Clear sequencing, pending flag and done pulse
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_clr_idx  <= '0;
            r_clr_pend <= 1'b0;
            r_clr_done <= 1'b0;
        end else begin
            r_clr_idx  <= (r_state == StClear) ? r_clr_idx + 1'b1 : '0;
            r_clr_pend <= w_enter_clear ? 1'b0 : w_clr_pend;
            r_clr_done <= (r_state == StClear) && w_clr_last;
        end
    end

    // Debug response data, held until the next DBG cycle
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_dbg_rdat <= '0;
        end else if (r_state == StDbg) begin
            r_dbg_rdat <= i_dbg_req_write ? i_dbg_wdat : i_rf_reg_out;
        end
    end

    assign o_clr_done = r_clr_done;
    assign o_dbg_rdat = r_dbg_rdat;

endmodule

// File: tb/tb_rf_access_ctrl.sv
// tb_rf_access_ctrl: directed, table-driven bench for rf_access_ctrl with a small register file
// model on the write port.
module tb_rf_access_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       core_acc_wr, core_reg_wr, core_imm;
    logic [4:0] core_addr;
    logic [7:0] core_dat;
    logic       core_stall;
    logic       clr_start, clr_busy, clr_done;
    logic       dbg_req_valid, dbg_req_write;
    logic [3:0] dbg_addr;
    logic [7:0] dbg_wdat;
    logic       dbg_req_ready, dbg_rsp_valid, dbg_rsp_ready;
    logic [7:0] dbg_rdat;
    logic [7:0] rf_dat_in;
    logic       rf_acc_write, rf_reg_write, rf_imm_val;
    logic [4:0] rf_addr;
    logic [7:0] rf_reg_out;

    logic [7:0] rf_mem [16];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         done_cnt = 0;

    always #5 clk = ~clk;

    rf_access_ctrl dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_core_acc_wr   (core_acc_wr),
        .i_core_reg_wr   (core_reg_wr),
        .i_core_imm      (core_imm),
        .i_core_addr     (core_addr),
        .i_core_dat      (core_dat),
        .o_core_stall    (core_stall),
        .i_clr_start     (clr_start),
        .o_clr_busy      (clr_busy),
        .o_clr_done      (clr_done),
        .i_dbg_req_valid (dbg_req_valid),
        .i_dbg_req_write (dbg_req_write),
        .i_dbg_addr      (dbg_addr),
        .i_dbg_wdat      (dbg_wdat),
        .o_dbg_req_ready (dbg_req_ready),
        .o_dbg_rsp_valid (dbg_rsp_valid),
        .i_dbg_rsp_ready (dbg_rsp_ready),
        .o_dbg_rdat      (dbg_rdat),
        .o_rf_dat_in     (rf_dat_in),
        .o_rf_acc_write  (rf_acc_write),
        .o_rf_reg_write  (rf_reg_write),
        .o_rf_imm_val    (rf_imm_val),
        .o_rf_addr       (rf_addr),
        .i_rf_reg_out    (rf_reg_out)
    );

    // Register file model: accumulator write wins when both enables are high.
    assign rf_reg_out = rf_mem[rf_addr[3:0]];
    always @(posedge clk) begin
        if (rf_acc_write) rf_mem[0] <= rf_dat_in;
        else if (rf_reg_write) rf_mem[rf_addr[3:0]] <= rf_dat_in;
    end

    always @(negedge clk) if (clr_done) done_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One debug transaction; returns cycles spent waiting in IDLE before ready.
    // During `hold` extra RSP cycles the core writes entry 9 to prove dbg_rdat stays put.
    task automatic dbg_xact(input logic wr, input logic [3:0] a, input logic [7:0] wd,
                            input logic [7:0] exp_rd, input int hold, output int wait_cyc);
        dbg_req_valid = 1'b1;
        dbg_req_write = wr;
        dbg_addr      = a;
        dbg_wdat      = wd;
        wait_cyc      = 0;
        @(negedge clk);
        while (!dbg_req_ready && wait_cyc < 40) begin
            wait_cyc++;
            @(negedge clk);
        end
        check("dbg_ready", 32'(dbg_req_ready), 32'(1));
        check("dbg_rf_drive",
              32'({core_stall, rf_acc_write, rf_reg_write, rf_imm_val, rf_addr, rf_dat_in}),
              32'({1'b1, 1'b0, wr, 1'b0, {1'b0, a}, wd}));
        step();
        dbg_req_valid = 1'b0;
        for (int h = 0; h <= hold; h++) begin
            @(negedge clk);
            check("dbg_rsp", 32'({dbg_rsp_valid, core_stall, dbg_rdat}),
                  32'({1'b1, 1'b0, exp_rd}));
            if (h < hold) begin
                core_reg_wr = 1'b1;
                core_addr   = 5'd9;
                core_dat    = 8'hE0 + 8'(h);
            end
        end
        if (hold > 0) core_reg_wr = 1'b0;
        dbg_rsp_ready = 1'b1;
        step();
        dbg_rsp_ready = 1'b0;
        @(negedge clk);
        check("dbg_rsp_drop", 32'(dbg_rsp_valid), 32'(0));
    endtask

    typedef struct {
        logic       acc_wr, reg_wr, imm;
        logic [4:0] addr;
        logic [7:0] dat;
        logic       exp_acc, exp_reg, exp_imm;
        logic [4:0] exp_addr;
        logic [7:0] exp_dat;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int w;
        int done_before;

        vecs[0] = '{1'b0, 1'b1, 1'b0, 5'd5,  8'h3C, 1'b0, 1'b1, 1'b0, 5'd5,  8'h3C};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 5'd0,  8'h81, 1'b1, 1'b0, 1'b0, 5'd0,  8'h81};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 5'h1F, 8'h00, 1'b0, 1'b0, 1'b1, 5'h1F, 8'h00};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 5'd2,  8'h42, 1'b1, 1'b1, 1'b0, 5'd2,  8'h42};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 5'd15, 8'hF0, 1'b0, 1'b1, 1'b0, 5'd15, 8'hF0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 5'h10, 8'h99, 1'b0, 1'b0, 1'b0, 5'h10, 8'h99};

        reset = 1'b1;
        core_acc_wr = 1'b0; core_reg_wr = 1'b0; core_imm = 1'b0;
        core_addr = '0; core_dat = '0;
        clr_start = 1'b0;
        dbg_req_valid = 1'b0; dbg_req_write = 1'b0; dbg_addr = '0; dbg_wdat = '0;
        dbg_rsp_ready = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        @(negedge clk);
        check("reset_flags",
              32'({core_stall, clr_busy, clr_done, dbg_req_ready, dbg_rsp_valid, dbg_rdat}), 32'(0));

        // Core pass-through in IDLE
        for (int i = 0; i < 6; i++) begin
            step();
            core_acc_wr = vecs[i].acc_wr;
            core_reg_wr = vecs[i].reg_wr;
            core_imm    = vecs[i].imm;
            core_addr   = vecs[i].addr;
            core_dat    = vecs[i].dat;
            @(negedge clk);
            check($sformatf("core_vec%0d", i),
                  32'({core_stall, rf_acc_write, rf_reg_write, rf_imm_val, rf_addr, rf_dat_in}),
                  32'({1'b0, vecs[i].exp_acc, vecs[i].exp_reg, vecs[i].exp_imm,
                       vecs[i].exp_addr, vecs[i].exp_dat}));
        end
        step();
        core_acc_wr = 1'b0; core_reg_wr = 1'b0; core_imm = 1'b0;

        // Debug write then read of entry 7, core idle
        dbg_xact(1'b1, 4'd7, 8'hA5, 8'hA5, 0, w);
        check("dbg_wr_latency", 32'(w), 32'(1));
        step();
        dbg_xact(1'b0, 4'd7, 8'h00, 8'hA5, 0, w);
        check("dbg_rd_latency", 32'(w), 32'(1));

        // Starvation: core writes every cycle while a debug read waits
        step();
        core_reg_wr = 1'b1; core_addr = 5'd3; core_dat = 8'h11;
        dbg_xact(1'b0, 4'd7, 8'h00, 8'hA5, 0, w);
        check("starve_wait", 32'(w), 32'(9));
        core_reg_wr = 1'b0;

        // Bulk clear
        step();
        done_before = done_cnt;
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check($sformatf("clear_idx%0d", i),
                  32'({clr_busy, core_stall, clr_done, rf_acc_write, rf_reg_write, rf_imm_val,
                       rf_addr, rf_dat_in}),
                  32'({1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'(i), 8'h00}));
        end
        @(negedge clk);
        check("clear_done", 32'({clr_busy, core_stall, clr_done}), 32'({1'b0, 1'b0, 1'b1}));
        @(negedge clk);
        check("clear_done_once", 32'(done_cnt - done_before), 32'(1));
        step();
        dbg_xact(1'b0, 4'd0, 8'h00, 8'h00, 0, w);
        step();
        dbg_xact(1'b0, 4'd15, 8'h00, 8'h00, 0, w);

        // Clear and debug write requested together: clear first, then hold the response
        step();
        done_before = done_cnt;
        clr_start = 1'b1;
        fork
            begin
                step();
                clr_start = 1'b0;
            end
        join_none
        dbg_xact(1'b1, 4'd9, 8'h77, 8'h77, 5, w);
        check("clr_before_dbg_wait", 32'(w), 32'(18));
        check("clr_before_dbg_done", 32'(done_cnt - done_before), 32'(1));

        // Reset in the middle of a clear
        step();
        done_before = done_cnt;
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        repeat (7) @(negedge clk);
        check("abort_idx", 32'({clr_busy, rf_addr}), 32'({1'b1, 5'd6}));
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check("abort_idle",
              32'({clr_busy, core_stall, clr_done, dbg_rsp_valid, dbg_rdat}), 32'(0));
        repeat (25) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - done_before), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
